// File: rtl/id_exe_hazard_ctrl.sv
// ID->EXE pipeline sequencer: shadow scoreboard of EXE/MEM destinations, RAW hazard
// detection, freeze/flush/bubble generation and the data-memory wait handshake.
module id_exe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_src2_use,
    input  logic [4:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             fwd_en,
    input  logic             exe_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_freeze,
    output logic             exmem_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_ERR
    } state_t;

    state_t          state;
    logic [WC_W-1:0] wcnt;

    logic       exe_v, exe_wb, exe_ld;
    logic [4:0] exe_dest;
    logic       mem_v, mem_wb;
    logic [4:0] mem_dest;

    logic src1_live, src2_live;
    logic hz_e, hz_m, hazard;
    logic mem_freeze, branch, stall;

    always_comb begin
        src1_live = id_valid && (id_src1 != '0);
        src2_live = id_valid && id_src2_use && (id_src2 != '0);

        hz_e = exe_v && exe_wb &&
               ((src1_live && (exe_dest == id_src1)) || (src2_live && (exe_dest == id_src2)));
        hz_m = mem_v && mem_wb &&
               ((src1_live && (mem_dest == id_src1)) || (src2_live && (mem_dest == id_src2)));

        // With forwarding only a load still in EXE cannot be bypassed in time.
        hazard = fwd_en ? (hz_e && exe_ld) : (hz_e || hz_m);

        mem_freeze = ((state == S_RUN)  && mem_req && !mem_ready) ||
                     ((state == S_WAIT) && !mem_ready) ||
                     (state == S_ERR);
        branch = exe_br_taken && !mem_freeze;
        stall  = hazard && !mem_freeze && !exe_br_taken;
    end

    assign pc_freeze    = mem_freeze || stall;
    assign ifid_freeze  = mem_freeze || stall;
    assign ifid_flush   = branch;
    assign idex_bubble  = branch || stall;
    assign idex_freeze  = mem_freeze;
    assign exmem_freeze = mem_freeze;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state <= S_WAIT;
                        wcnt  <= WC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        state <= S_RUN;
                    end else if (wcnt == WC_W'(TIMEOUT - 1)) begin
                        state   <= S_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                end
                default: state <= S_ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_v    <= 1'b0;
            exe_wb   <= 1'b0;
            exe_ld   <= 1'b0;
            exe_dest <= '0;
            mem_v    <= 1'b0;
            mem_wb   <= 1'b0;
            mem_dest <= '0;
        end else begin
            if (!idex_freeze) begin
                exe_v    <= id_valid && !idex_bubble;
                exe_wb   <= id_wb_en;
                exe_ld   <= id_mem_r_en;
                exe_dest <= id_dest;
            end
            if (!exmem_freeze) begin
                mem_v    <= exe_v;
                mem_wb   <= exe_wb;
                mem_dest <= exe_dest;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// Scenario bench for id_exe_hazard_ctrl: per-cycle expected controls and counters
// are queued when stimulus is applied and compared when the cycle's outputs settle.
module tb_id_exe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_src2_use, id_wb_en, id_mem_r_en;
    logic [4:0] id_src1, id_src2, id_dest;
    logic       fwd_en, exe_br_taken, mem_req, mem_ready;
    logic       pc_freeze, ifid_freeze, ifid_flush, idex_bubble;
    logic       idex_freeze, exmem_freeze, mem_err;
    logic [2:0] stall_cnt, flush_cnt;

    id_exe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src2_use(id_src2_use), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .fwd_en(fwd_en), .exe_br_taken(exe_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_freeze(idex_freeze), .exmem_freeze(exmem_freeze),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] s1, s2;
        logic       u;
        logic [4:0] d;
        logic       wb, ld, fwd, br, mreq, mrdy;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic [12:0] ex;
    } row_t;

    // {pc_frz, ifid_frz, ifid_flush, idex_bubble, idex_frz, exmem_frz, mem_err}
    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] STALL = 7'b1101000;
    localparam logic [6:0] FLUSH = 7'b0011000;
    localparam logic [6:0] MFRZ  = 7'b1100110;
    localparam logic [6:0] MERR  = 7'b1100111;

    logic [12:0] obs;
    assign obs = {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, idex_freeze,
                  exmem_freeze, mem_err, stall_cnt, flush_cnt};

    logic [12:0] exp_q[$];
    logic [12:0] ex;
    int errors = 0;
    int checks = 0;

    function automatic in_t mk(input int v, input int s1, input int s2, input int u,
                               input int d, input int wb, input int ld, input int fwd,
                               input int br, input int mreq, input int mrdy);
        in_t t;
        t.v = 1'(v); t.s1 = 5'(s1); t.s2 = 5'(s2); t.u = 1'(u); t.d = 5'(d);
        t.wb = 1'(wb); t.ld = 1'(ld); t.fwd = 1'(fwd); t.br = 1'(br);
        t.mreq = 1'(mreq); t.mrdy = 1'(mrdy);
        return t;
    endfunction

    function automatic row_t r(input in_t i, input logic [6:0] c, input int sc, input int fc);
        row_t x;
        x.in = i;
        x.ex = {c, 3'(sc), 3'(fc)};
        return x;
    endfunction

    task automatic drive(input in_t t);
        id_valid = t.v; id_src1 = t.s1; id_src2 = t.s2; id_src2_use = t.u;
        id_dest = t.d; id_wb_en = t.wb; id_mem_r_en = t.ld; fwd_en = t.fwd;
        exe_br_taken = t.br; mem_req = t.mreq; mem_ready = t.mrdy;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive('0);
        #3;
        exp_q.push_back(13'b0);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", obs, ex);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        drive(mk(0,0,0,0,0,0,0,1,0,0,0));
        exp_q.push_back({NONE, 3'd0, 3'd0});
        @(negedge clk);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", obs, ex);
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        do_reset();
        rows.push_back(r(mk(1,0,0,0,5,1,1,1,0,0,0), NONE,  0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,0,0,0), STALL, 0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,0,0,0), NONE,  1, 0));
        rows.push_back(r(mk(0,0,0,0,0,0,0,1,0,0,0), NONE,  1, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i].in);
            exp_q.push_back(rows[i].ex);
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b want %b", i, obs, ex);
            end
        end
    endtask

    task automatic test_no_fwd();
        row_t rows[$];
        do_reset();
        rows.push_back(r(mk(1,0,0,0,3,1,0,0,0,0,0), NONE,  0, 0));
        rows.push_back(r(mk(1,0,3,1,7,1,0,0,0,0,0), STALL, 0, 0));
        rows.push_back(r(mk(1,0,3,1,7,1,0,0,0,0,0), STALL, 1, 0));
        rows.push_back(r(mk(1,0,3,1,7,1,0,0,0,0,0), NONE,  2, 0));
        rows.push_back(r(mk(0,0,0,0,0,0,0,0,0,0,0), NONE,  2, 0));
        rows.push_back(r(mk(1,0,0,0,3,1,0,0,0,0,0), NONE,  2, 0));
        rows.push_back(r(mk(1,0,3,0,8,1,0,0,0,0,0), NONE,  2, 0));
        rows.push_back(r(mk(0,0,0,0,0,0,0,0,0,0,0), NONE,  2, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i].in);
            exp_q.push_back(rows[i].ex);
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL no_fwd[%0d]: got %b want %b", i, obs, ex);
            end
        end
    endtask

    task automatic test_r0();
        row_t rows[$];
        do_reset();
        rows.push_back(r(mk(1,0,0,0,0,1,1,1,0,0,0), NONE, 0, 0));
        rows.push_back(r(mk(1,0,0,1,9,0,0,1,0,0,0), NONE, 0, 0));
        rows.push_back(r(mk(1,0,0,1,9,0,0,0,0,0,0), NONE, 0, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i].in);
            exp_q.push_back(rows[i].ex);
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL r0[%0d]: got %b want %b", i, obs, ex);
            end
        end
    endtask

    task automatic test_branch_vs_hazard();
        row_t rows[$];
        do_reset();
        rows.push_back(r(mk(1,0,0,0,5,1,1,1,0,0,0), NONE,  0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,1,0,0), FLUSH, 0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,0,0,0), NONE,  0, 1));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i].in);
            exp_q.push_back(rows[i].ex);
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL branch_vs_hazard[%0d]: got %b want %b", i, obs, ex);
            end
        end
    endtask

    task automatic test_mem_wait();
        row_t rows[$];
        do_reset();
        rows.push_back(r(mk(1,0,0,0,5,1,1,1,0,0,0), NONE,  0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,1,1,0), MFRZ,  0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,1,1,0), MFRZ,  0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,1,1,0), MFRZ,  0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,1,1,1), FLUSH, 0, 0));
        rows.push_back(r(mk(1,5,0,0,6,1,0,1,0,0,0), NONE,  0, 1));
        rows.push_back(r(mk(0,0,0,0,0,0,0,1,0,1,1), NONE,  0, 1));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i].in);
            exp_q.push_back(rows[i].ex);
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, ex);
            end
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        do_reset();
        rows.push_back(r(mk(0,0,0,0,0,0,0,1,0,1,0), MFRZ, 0, 0));
        rows.push_back(r(mk(0,0,0,0,0,0,0,1,0,1,0), MFRZ, 0, 0));
        rows.push_back(r(mk(0,0,0,0,0,0,0,1,0,1,0), MFRZ, 0, 0));
        rows.push_back(r(mk(0,0,0,0,0,0,0,1,0,1,0), MFRZ, 0, 0));
        rows.push_back(r(mk(0,0,0,0,0,0,0,1,0,1,0), MERR, 0, 0));
        rows.push_back(r(mk(0,0,0,0,0,0,0,1,1,0,1), MERR, 0, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i].in);
            exp_q.push_back(rows[i].ex);
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL timeout[%0d]: got %b want %b", i, obs, ex);
            end
        end
        @(posedge clk); #2;
        drive(mk(0,0,0,0,0,0,0,1,0,0,0));
        rst = 1'b0;
        #1;
        exp_q.push_back({NONE, 3'd0, 3'd0});
        ex = exp_q.pop_front();
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL err_reset: got %b want %b", obs, ex);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({NONE, 3'd0, 3'd0});
        @(negedge clk);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL err_reset_run: got %b want %b", obs, ex);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        @(posedge clk); #1;
        drive(mk(0,0,0,0,0,0,0,1,0,1,0));
        exp_q.push_back({MFRZ, 3'd0, 3'd0});
        @(negedge clk);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL wait_enter: got %b want %b", obs, ex);
        end
        @(posedge clk); #1;
        drive(mk(0,0,0,0,0,0,0,1,0,0,0));
        exp_q.push_back({MFRZ, 3'd0, 3'd0});
        #1;
        ex = exp_q.pop_front();
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL wait_hold: got %b want %b", obs, ex);
        end
        rst = 1'b0;
        #1;
        exp_q.push_back({NONE, 3'd0, 3'd0});
        ex = exp_q.pop_front();
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL wait_reset: got %b want %b", obs, ex);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({NONE, 3'd0, 3'd0});
        @(negedge clk);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL wait_reset_run: got %b want %b", obs, ex);
        end
    endtask

    task automatic test_saturation();
        row_t rows[$];
        do_reset();
        for (int i = 0; i < 10; i++)
            rows.push_back(r(mk(0,0,0,0,0,0,0,1,1,0,0), FLUSH, 0, (i < 7) ? i : 7));
        // Self-dependent load alternates advance/stall with forwarding on.
        for (int i = 0; i < 20; i++)
            rows.push_back(r(mk(1,3,0,0,3,1,1,1,0,0,0), (i % 2 == 1) ? STALL : NONE,
                             (i / 2 < 7) ? i / 2 : 7, 7));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i].in);
            exp_q.push_back(rows[i].ex);
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL saturation[%0d]: got %b want %b", i, obs, ex);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_fwd();
        test_r0();
        test_branch_vs_hazard();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
